// File: rtl/hps_ext_pkg.sv
// Shared command codes, reply word layouts and window decode helpers for the HPS extension mux.
package hps_ext_pkg;

  localparam int unsigned N_CMDS = 6;

  localparam logic [2:0] OFS_GET_STATUS = 3'd0;
  localparam logic [2:0] OFS_GET_CTRL   = 3'd1;
  localparam logic [2:0] OFS_SET_CTRL   = 3'd2;
  localparam logic [2:0] OFS_SET_CHAN   = 3'd3;
  localparam logic [2:0] OFS_SET_STREAM = 3'd4;
  localparam logic [2:0] OFS_GET_INFO   = 3'd5;

  // Header word returned on word 0 of every decoded command
  typedef struct packed {
    logic       ovf;
    logic       fifo_valid;
    logic [5:0] rsvd;
    logic [7:0] evt_cnt;
  } ext_hdr_t;

  // Geometry word returned by GET_INFO word 1
  typedef struct packed {
    logic [3:0] n_chan_m1;
    logic [3:0] n_ctrl_m1;
    logic [4:0] n_status_m1;
    logic [2:0] rsvd;
  } ext_info_t;

  // 17-bit difference so codes below base wrap high and fall outside the window
  function automatic logic cmd_in_win(input logic [15:0] code, input logic [15:0] base);
    logic [16:0] d;
    d = {1'b0, code} - {1'b0, base};
    return (d <= 17'(N_CMDS - 1));
  endfunction

  function automatic logic [2:0] cmd_ofs(input logic [15:0] code, input logic [15:0] base);
    return 3'(code - base);
  endfunction

endpackage

// File: rtl/hps_ext_fifo.sv
// First-word fall-through stream FIFO; a push into a full FIFO is still taken when a pop happens the same cycle.
module hps_ext_fifo
  import hps_ext_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [15:0]              wdata,
  input  logic                     pop,
  output logic [15:0]              rdata_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_nxt;
  logic                   pop_ok;
  logic                   push_ok;

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop_c  = push & ~push_ok;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/hps_ext_mux.sv
// HPS extension command decoder on EXT_BUS: status snapshot, control registers,
// sticky request channels and a word stream FIFO toward the core.
module hps_ext_mux
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_BASE   = 16'hf0,
  parameter int unsigned N_STATUS   = 8,
  parameter int unsigned N_CTRL     = 4,
  parameter int unsigned N_CHAN     = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  inout  wire  [35:0]             EXT_BUS,
  input  logic                    evt_toggle,
  input  logic [16*N_STATUS-1:0]  status_in,
  output logic [16*N_CTRL-1:0]    ctrl_out,
  output logic [N_CHAN-1:0]       chan_req,
  output logic [16*N_CHAN-1:0]    chan_arg,
  input  logic [N_CHAN-1:0]       chan_ack,
  output logic [15:0]             fifo_data,
  output logic                    fifo_valid,
  input  logic                    fifo_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] io_din;
  logic        io_strobe;
  logic        io_enable;

  logic [7:0]                 wc, wc_nxt;
  logic [15:0]                cmd, cmd_nxt;
  logic [15:0]                idx, idx_nxt;
  logic                       dout_en, dout_en_nxt;
  logic [15:0]                io_dout, io_dout_nxt;
  logic [N_CTRL-1:0][15:0]    ctrl_q, ctrl_nxt;
  logic [N_CHAN-1:0][15:0]    arg_q, arg_nxt;
  logic [N_CHAN-1:0]          chan_req_nxt;
  logic [N_STATUS-1:0][15:0]  snap_q, snap_nxt;
  logic                       overflow, overflow_nxt;
  logic [7:0]                 evt_cnt, evt_cnt_nxt;
  logic                       evt_prev;

  logic                       hit;
  logic [2:0]                 ofs;
  logic                       data_stb;
  logic                       push_c;
  logic                       ovf_clr_c;
  logic                       drop_c;
  logic [CW-1:0]              f_count;
  logic                       f_full;
  logic                       f_empty;
  ext_hdr_t                   hdr;
  ext_info_t                  info;
  logic                       unused_bits;

  assign io_din    = EXT_BUS[31:16];
  assign io_strobe = EXT_BUS[33];
  assign io_enable = EXT_BUS[34];

  assign EXT_BUS[15:0] = io_dout;
  assign EXT_BUS[32]   = dout_en;

  assign unused_bits = ^{EXT_BUS[35], f_full};

  assign hit      = cmd_in_win(cmd, CMD_BASE);
  assign ofs      = cmd_ofs(cmd, CMD_BASE);
  assign data_stb = io_enable & io_strobe & (wc != 8'd0) & hit;

  // Stream pushes are independent of wc saturation; overflow clears on the third GET_INFO word
  assign push_c    = data_stb & (ofs == OFS_SET_STREAM);
  assign ovf_clr_c = data_stb & (ofs == OFS_GET_INFO) & (wc == 8'd3);

  assign hdr  = '{ovf: overflow, fifo_valid: fifo_valid, rsvd: 6'd0, evt_cnt: evt_cnt};
  assign info = '{n_chan_m1: 4'(N_CHAN - 1), n_ctrl_m1: 4'(N_CTRL - 1),
                  n_status_m1: 5'(N_STATUS - 1), rsvd: 3'd0};

  assign ctrl_out   = ctrl_q;
  assign chan_arg   = arg_q;
  assign fifo_valid = ~f_empty;

  always_comb begin
    wc_nxt       = wc;
    cmd_nxt      = cmd;
    idx_nxt      = idx;
    dout_en_nxt  = dout_en;
    io_dout_nxt  = io_dout;
    ctrl_nxt     = ctrl_q;
    arg_nxt      = arg_q;
    chan_req_nxt = chan_req & ~chan_ack;
    snap_nxt     = snap_q;
    overflow_nxt = (overflow & ~ovf_clr_c) | drop_c;
    evt_cnt_nxt  = evt_cnt + 8'(evt_toggle ^ evt_prev);

    if (!io_enable) begin
      wc_nxt      = 8'd0;
      cmd_nxt     = 16'd0;
      dout_en_nxt = 1'b0;
      io_dout_nxt = 16'd0;
    end else if (io_strobe) begin
      if (wc != 8'hff) wc_nxt = wc + 8'd1;
      if (wc == 8'd0) begin
        cmd_nxt     = io_din;
        dout_en_nxt = cmd_in_win(io_din, CMD_BASE);
        io_dout_nxt = dout_en_nxt ? 16'(hdr) : 16'd0;
      end else begin
        io_dout_nxt = 16'd0;
        if (hit) begin
          case (ofs)
            OFS_GET_STATUS: begin
              if (wc == 8'd1) begin
                snap_nxt    = status_in;
                io_dout_nxt = status_in[15:0];
              end else begin
                for (int unsigned i = 1; i < N_STATUS; i++)
                  if (wc == 8'(i + 1)) io_dout_nxt = snap_q[i];
              end
            end
            OFS_GET_CTRL: begin
              for (int unsigned i = 0; i < N_CTRL; i++)
                if (wc == 8'(i + 1)) io_dout_nxt = ctrl_q[i];
            end
            OFS_SET_CTRL: begin
              if (wc == 8'd1) begin
                idx_nxt = io_din;
              end else begin
                // idx parks at N_CTRL once past the end so later words stay ignored
                for (int unsigned i = 0; i < N_CTRL; i++)
                  if (idx == 16'(i)) ctrl_nxt[i] = io_din;
                if (idx < 16'(N_CTRL)) idx_nxt = idx + 16'd1;
              end
            end
            OFS_SET_CHAN: begin
              if (wc == 8'd1) begin
                idx_nxt = io_din;
              end else if (wc == 8'd2) begin
                // Set overrides a same-cycle acknowledge
                for (int unsigned i = 0; i < N_CHAN; i++)
                  if (idx == 16'(i)) begin
                    arg_nxt[i]      = io_din;
                    chan_req_nxt[i] = 1'b1;
                  end
              end
            end
            OFS_GET_INFO: begin
              case (wc)
                8'd1:    io_dout_nxt = 16'(info);
                8'd2:    io_dout_nxt = 16'(f_count);
                8'd3:    io_dout_nxt = {15'd0, overflow};
                default: io_dout_nxt = 16'd0;
              endcase
            end
            default: io_dout_nxt = 16'd0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wc       <= 8'd0;
      cmd      <= 16'd0;
      idx      <= 16'd0;
      dout_en  <= 1'b0;
      io_dout  <= 16'd0;
      ctrl_q   <= '0;
      arg_q    <= '0;
      chan_req <= '0;
      snap_q   <= '0;
      overflow <= 1'b0;
      evt_cnt  <= 8'd0;
      evt_prev <= 1'b0;
    end else begin
      wc       <= wc_nxt;
      cmd      <= cmd_nxt;
      idx      <= idx_nxt;
      dout_en  <= dout_en_nxt;
      io_dout  <= io_dout_nxt;
      ctrl_q   <= ctrl_nxt;
      arg_q    <= arg_nxt;
      chan_req <= chan_req_nxt;
      snap_q   <= snap_nxt;
      overflow <= overflow_nxt;
      evt_cnt  <= evt_cnt_nxt;
      evt_prev <= evt_toggle;
    end
  end

  hps_ext_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .push    (push_c),
    .wdata   (io_din),
    .pop     (fifo_ready),
    .rdata_c (fifo_data),
    .count   (f_count),
    .full    (f_full),
    .empty   (f_empty),
    .drop_c  (drop_c)
  );

endmodule

// File: tb/tb_hps_ext_mux.sv
// Scoreboard bench for hps_ext_mux: bus replies and FIFO pops are checked against queued expectations.
module tb_hps_ext_mux;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  wire  [35:0]  bus;
  logic [15:0]  din;
  logic         strobe;
  logic         en;
  logic         evt_toggle;
  logic [127:0] status_in;
  logic [63:0]  ctrl_out;
  logic [3:0]   chan_req;
  logic [63:0]  chan_arg;
  logic [3:0]   chan_ack;
  logic [15:0]  fifo_data;
  logic         fifo_valid;
  logic         fifo_ready;

  assign bus[31:16] = din;
  assign bus[33]    = strobe;
  assign bus[34]    = en;
  assign bus[35]    = 1'b0;

  always #5 clk_sys = ~clk_sys;

  hps_ext_mux dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .EXT_BUS    (bus),
    .evt_toggle (evt_toggle),
    .status_in  (status_in),
    .ctrl_out   (ctrl_out),
    .chan_req   (chan_req),
    .chan_arg   (chan_arg),
    .chan_ack   (chan_ack),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [16:0] exp_q[$];
  string       nm_q[$];
  logic [15:0] fq[$];
  logic        cur_en;
  logic [3:0]  ack_with_strobe;
  logic        strobe_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issue one bus word and queue the reply it must produce
  task automatic word(input logic [15:0] d, input logic [15:0] exp, input string nm);
    exp_q.push_back({cur_en, exp});
    nm_q.push_back(nm);
    din      = d;
    strobe   = 1'b1;
    chan_ack = ack_with_strobe;
    tick();
    strobe   = 1'b0;
    chan_ack = 4'd0;
    tick();
  endtask

  task automatic frame_start(input logic [15:0] c, input logic win, input logic [15:0] hdr);
    en     = 1'b1;
    cur_en = win;
    tick();
    word(c, hdr, "header");
  endtask

  task automatic frame_end();
    en = 1'b0;
    tick();
    tick();
  endtask

  always @(posedge clk_sys) strobe_seen <= en & strobe;

  // Bus reply monitor
  always @(negedge clk_sys) begin
    if (strobe_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_reply", 64'(1), 64'(0));
      end else begin
        logic [16:0] e;
        string       n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, 64'({bus[32], bus[15:0]}), 64'(e));
      end
    end
  end

  // FIFO pop monitor
  always @(negedge clk_sys) begin
    if (fifo_valid && fifo_ready) begin
      if (fq.size() == 0) begin
        chk("unexpected_pop", 64'(1), 64'(0));
      end else begin
        logic [15:0] e;
        e = fq.pop_front();
        chk("fifo_pop", 64'(fifo_data), 64'(e));
      end
    end
  end

  initial begin
    reset_n         = 1'b0;
    din             = 16'd0;
    strobe          = 1'b0;
    en              = 1'b0;
    evt_toggle      = 1'b0;
    status_in       = '0;
    chan_ack        = 4'd0;
    fifo_ready      = 1'b0;
    cur_en          = 1'b0;
    ack_with_strobe = 4'd0;
    repeat (3) tick();
    chk("rst_ctrl_out", ctrl_out, 64'd0);
    chk("rst_chan", 64'({chan_req, chan_arg}), 64'd0);
    chk("rst_fifo", 64'({fifo_valid, fifo_data}), 64'd0);
    chk("rst_bus", 64'({bus[32], bus[15:0]}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Two event edges, then header and geometry
    evt_toggle = 1'b1; tick(); tick();
    evt_toggle = 1'b0; tick(); tick();
    frame_start(16'h00f5, 1'b1, 16'h0002);
    word(16'h0000, 16'h3338, "info_geom");
    word(16'h0000, 16'h0000, "info_count0");
    word(16'h0000, 16'h0000, "info_ovf0");
    frame_end();

    // Status snapshot
    for (int i = 0; i < 8; i++)
      status_in[16*i +: 16] = (i == 0) ? 16'h1234 : 16'h1000 + 16'(i);
    frame_start(16'h00f0, 1'b1, 16'h0002);
    word(16'h0000, 16'h1234, "status_w0");
    status_in = {8{16'hdead}};
    for (int k = 2; k <= 8; k++)
      word(16'h0000, 16'h1000 + 16'(k - 1), "status_snap");
    word(16'h0000, 16'h0000, "status_beyond");
    frame_end();

    // SET_CTRL starting at idx 2: third data word falls off the end
    frame_start(16'h00f2, 1'b1, 16'h0002);
    word(16'h0002, 16'h0000, "setctrl_idx");
    word(16'haaaa, 16'h0000, "setctrl_a");
    word(16'hbbbb, 16'h0000, "setctrl_b");
    word(16'hcccc, 16'h0000, "setctrl_c");
    frame_end();
    chk("ctrl_out", ctrl_out, 64'hbbbb_aaaa_0000_0000);
    frame_start(16'h00f1, 1'b1, 16'h0002);
    word(16'h0000, 16'h0000, "getctrl0");
    word(16'h0000, 16'h0000, "getctrl1");
    word(16'h0000, 16'haaaa, "getctrl2");
    word(16'h0000, 16'hbbbb, "getctrl3");
    word(16'h0000, 16'h0000, "getctrl_beyond");
    frame_end();

    // Channel set, set racing ack, then a lone ack
    frame_start(16'h00f3, 1'b1, 16'h0002);
    word(16'h0001, 16'h0000, "chan_idx");
    word(16'h00aa, 16'h0000, "chan_arg");
    frame_end();
    chk("chan_req_set", 64'(chan_req), 64'(4'b0010));
    chk("chan_arg_set", chan_arg, 64'h0000_0000_00aa_0000);
    frame_start(16'h00f3, 1'b1, 16'h0002);
    word(16'h0001, 16'h0000, "chan_idx2");
    ack_with_strobe = 4'b0010;
    word(16'h00bb, 16'h0000, "chan_arg2");
    ack_with_strobe = 4'b0000;
    frame_end();
    chk("chan_req_set_wins", 64'(chan_req), 64'(4'b0010));
    chk("chan_arg_update", chan_arg, 64'h0000_0000_00bb_0000);
    chan_ack = 4'b0010; tick();
    chan_ack = 4'b0000; tick();
    chk("chan_req_acked", 64'(chan_req), 64'(4'b0000));

    // Stream 17 words into a 16-deep FIFO with no consumer
    frame_start(16'h00f4, 1'b1, 16'h0002);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) fq.push_back(16'h5000 + 16'(i));
      word(16'h5000 + 16'(i), 16'h0000, "stream");
    end
    frame_end();
    frame_start(16'h00f5, 1'b1, 16'hc002);
    word(16'h0000, 16'h3338, "info_geom2");
    word(16'h0000, 16'h0010, "info_count16");
    word(16'h0000, 16'h0001, "info_ovf1");
    frame_end();
    frame_start(16'h00f5, 1'b1, 16'h4002);
    word(16'h0000, 16'h3338, "info_geom3");
    word(16'h0000, 16'h0010, "info_count16b");
    word(16'h0000, 16'h0000, "info_ovf_cleared");
    frame_end();
    fifo_ready = 1'b1;
    for (int t = 0; t < 100 && fifo_valid; t++) tick();
    fifo_ready = 1'b0;
    chk("fifo_drained", 64'({fifo_valid, 31'(fq.size())}), 64'd0);

    // Aborted SET_CHAN after the index word
    frame_start(16'h00f3, 1'b1, 16'h0002);
    word(16'h0002, 16'h0000, "abort_idx");
    frame_end();
    chk("abort_no_req", 64'({chan_req, chan_arg[47:32]}), 64'd0);
    chk("disabled_bus", 64'({bus[32], bus[15:0]}), 64'd0);

    // Unknown command: silent and side-effect free
    frame_start(16'h0010, 1'b0, 16'h0000);
    word(16'h0003, 16'h0000, "unk_w1");
    word(16'h1111, 16'h0000, "unk_w2");
    frame_end();
    chk("unk_state", 64'({chan_req, fifo_valid}), 64'd0);
    chk("unk_ctrl", ctrl_out, 64'hbbbb_aaaa_0000_0000);
    chk("replies_consumed", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hps_ext_mux.md
Name: hps_ext_mux

Overview:
- Parametrised successor to the per-core HPS extension decoder on EXT_BUS.
- Decodes a window of 6 commands starting at CMD_BASE and serves the HPS's need to:
  - read a snapshotted N_STATUS-word status block;
  - write and read back N_CTRL control registers;
  - raise N_CHAN sticky request channels, each with a 16-bit argument and a core-side acknowledge;
  - stream words into a FIFO for core-side consumers (audio, blit data).
- Sits between hps_io's EXT_BUS and the core's video, audio and blit engines.

Parameters:
- CMD_BASE, 'hf0: first command code. Offsets +0..+5 are decoded.
- N_STATUS, 8: 16-bit status words returned by GET_STATUS (1..32).
- N_CTRL, 4: 16-bit HPS-writable control registers (1..16).
- N_CHAN, 4: sticky request channels (1..16).
- FIFO_DEPTH, 16: stream FIFO depth in words (power of two, 4..256).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- EXT_BUS  inout  36  [15:0] io_dout, [31:16] io_din, [32] dout_en driven; [33] io_strobe, [34] io_enable sampled
- evt_toggle  in  1  event toggle; each edge increments the 8-bit event counter
- status_in  in  16*N_STATUS  live status words; word i = [16i+15:16i]
- ctrl_out  out  16*N_CTRL  control registers
- chan_req  out  N_CHAN  sticky requests
- chan_arg  out  16*N_CHAN  per-channel argument
- chan_ack  in  N_CHAN  1-cycle clear of chan_req
- fifo_data  out  16  FIFO head
- fifo_valid  out  1  FIFO not empty
- fifo_ready  in  1  pop when valid & ready

Behaviour:
- Reset (async, reset_n=0): every output and register is 0; FIFO is empty; overflow=0; event counter=0.
- Frame handling:
  - io_enable=0: dout_en=0, io_dout=0, word counter wc=0, cmd=0.
  - Each io_strobe while enabled advances wc by 1. wc is 8 bits and saturates at 255.
- wc=0:
  - cmd<=io_din.
  - dout_en<=(CMD_BASE<=io_din<=CMD_BASE+5).
  - If in window: io_dout<={overflow, fifo_valid, 6'd0, evt_cnt}; otherwise io_dout<=0.
- Reply timing: the reply for word n is registered into io_dout on strobe n. Words beyond a command's defined range return 0.
- +0 GET_STATUS:
  - wc=1: snapshot all of status_in; io_dout<=status_in word0 (live).
  - wc=k, 2..N_STATUS: io_dout<=snapshot word k-1.
- +1 GET_CTRL: wc=k, 1..N_CTRL: io_dout<=ctrl reg k-1.
- +2 SET_CTRL:
  - wc=1: idx<=io_din.
  - wc>=2: if idx<N_CTRL, ctrl[idx]<=io_din, then idx++. Writes with idx>=N_CTRL are ignored.
  - Each write is visible on ctrl_out the cycle after its strobe.
- +3 SET_CHAN:
  - wc=1: ch<=io_din.
  - wc=2: if ch<N_CHAN, chan_arg[ch]<=io_din and chan_req[ch]<=1.
  - The same cycle as chan_ack[ch]: set wins.
  - chan_ack while req=0: no effect.
- +4 SET_STREAM:
  - every word with wc>=1 is pushed into the FIFO, regardless of wc saturation.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow<=1 (sticky).
- +5 GET_INFO:
  - wc=1: io_dout<={N_CHAN-1[3:0], N_CTRL-1[3:0], N_STATUS-1[4:0], 3'd0}.
  - wc=2: io_dout<=FIFO count, zero-extended.
  - wc=3: io_dout<={15'd0, overflow}; overflow<=0 unless a drop occurs in the same cycle.
- FIFO:
  - First-word fall-through: fifo_data is valid in the cycle fifo_valid=1.
  - Pop and push in the same cycle keep count unchanged.
- Aborted frames: io_enable dropping mid-command aborts it. Completed ctrl writes, channel sets and pushes persist; a partial SET_CHAN (idx only) has no effect.
- Event counter: an evt_toggle edge is detected against the previous sample; the 8-bit counter wraps 255->0.

Decomposition:
- Package hps_ext_pkg: command offset constants (OFS_GET_STATUS=0 .. OFS_GET_INFO=5) and the header bit positions.
- Sub-module hps_ext_fifo: parametrised by DEPTH, with push, pop, count, full, empty, and the same-cycle push+pop rule.

Test Plan:
- Reset, then header: reset_n low; verify all outputs are 0. Two evt_toggle edges, then a frame with cmd 'hf5 -> word0 reply 16'h0002; wc=1 -> {3,3,7,0} for the defaults.
- Status snapshot: status_in word0=16'h1234; GET_STATUS; change status_in after wc=1 -> words 2..8 return the values at snapshot, not the changed ones.
- SET_CTRL wrap: cmd 'hf2, idx=2, data A,B,C -> ctrl2=A, ctrl3=B; C ignored; GET_CTRL returns 0,0,A,B.
- Channel handshake: SET_CHAN ch=1 arg=16'h00AA -> chan_req=4'b0010, chan_arg1=AA. chan_ack[1] asserted in the same cycle as a second set -> req stays 1; a later lone ack -> 0.
- FIFO overflow: fifo_ready=0; stream 17 words into the default FIFO -> count=16, overflow=1. GET_INFO wc=2 -> 16, wc=3 -> 1, then overflow reads 0. Pop order matches push order.
- Abort and unknown command: drop io_enable after SET_CHAN idx only -> no req. Command 'h10 -> dout_en=0, io_dout=0, state unchanged.
